// File: rtl/uart_scope_pkg.sv
// Shared definitions for the uart_scope command path: FSM state encoding,
// default header bytes, default inter-byte timeout and frame length.
// Frame length follows the optional checksum feature (UART_CMD_CHECKSUM_EN).
package uart_scope_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_ADDR = 3'd2;
    localparam state_t ST_DATH = 3'd3;
    localparam state_t ST_DATL = 3'd4;
    localparam state_t ST_CHK  = 3'd5;
    localparam state_t ST_OUT  = 3'd6;

    localparam logic [7:0] DEF_HDR0        = 8'h55;
    localparam logic [7:0] DEF_HDR1        = 8'hA5;
    localparam int         DEF_TIMEOUT_CYC = 500000;

`ifdef UART_CMD_CHECKSUM_EN
    localparam int FRAME_LEN = 6;
`else
    localparam int FRAME_LEN = 5;
`endif

endpackage

// File: rtl/uart_gap_timer.sv
// Saturating inter-byte gap counter. Counts while enabled, clears on every
// received byte (or when disabled), and flags expiry when the count sits at
// TIMEOUT_CYC-1 with no byte arriving in that same cycle.
module uart_gap_timer
    import uart_scope_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_d, cnt_q;

    // Next count: clear wins, idle holds zero, otherwise count up and stick at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // A byte in the expiry cycle takes precedence over the timeout.
    assign expire = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Command-frame decoder behind the UART byte receiver. Assembles
// HDR0 HDR1 ADDR DATA_H DATA_L [CHK] frames and emits one register-write
// command per good frame. Optional checksum byte: define UART_CMD_CHECKSUM_EN.
module uart_cmd_decoder
    import uart_scope_pkg::*;
#(
    parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter logic [7:0] HDR0        = DEF_HDR0,
    parameter logic [7:0] HDR1        = DEF_HDR1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_done,
    output logic        cmd_valid,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        frame_err,
    output logic        busy
);

    state_t      state_d, state_q;
    logic [7:0]  addr_sh_d, addr_sh_q;
    logic [7:0]  dath_sh_d, dath_sh_q;
    logic [7:0]  datl_sh_d, datl_sh_q;
    logic [7:0]  cmd_addr_d, cmd_addr_q;
    logic [15:0] cmd_data_d, cmd_data_q;
    logic        cmd_valid_d, cmd_valid_q;
    logic        frame_err_d, frame_err_q;
    logic        expire;

    assign busy = (state_q != ST_IDLE);

    uart_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_done),
        .enable (busy),
        .expire (expire)
    );

    // Frame FSM, shadow capture and output update; outputs only move in OUT.
    always_comb begin
        state_d     = state_q;
        addr_sh_d   = addr_sh_q;
        dath_sh_d   = dath_sh_q;
        datl_sh_d   = datl_sh_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: if (rx_done && rx_byte == HDR0) state_d = ST_HDR;
            ST_HDR: begin
                if (rx_done) begin
                    if (rx_byte == HDR1)      state_d = ST_ADDR;
                    else if (rx_byte == HDR0) state_d = ST_HDR;
                    else                      state_d = ST_IDLE;
                end
            end
            ST_ADDR: if (rx_done) begin addr_sh_d = rx_byte; state_d = ST_DATH; end
            ST_DATH: if (rx_done) begin dath_sh_d = rx_byte; state_d = ST_DATL; end
            ST_DATL: begin
                if (rx_done) begin
                    datl_sh_d = rx_byte;
`ifdef UART_CMD_CHECKSUM_EN
                    state_d   = ST_CHK;
`else
                    state_d   = ST_OUT;
`endif
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            ST_CHK: begin
                if (rx_done) begin
                    if (rx_byte == (addr_sh_q ^ dath_sh_q ^ datl_sh_q)) begin
                        state_d = ST_OUT;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
`endif
            ST_OUT: begin
                cmd_addr_d  = addr_sh_q;
                cmd_data_d  = {dath_sh_q, datl_sh_q};
                cmd_valid_d = 1'b1;
                // A byte landing here is treated as if already back in IDLE.
                state_d     = (rx_done && rx_byte == HDR0) ? ST_HDR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (expire) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            addr_sh_d   = '0;
            dath_sh_d   = '0;
            datl_sh_d   = '0;
        end
    end

    // State, shadow and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_sh_q   <= '0;
            dath_sh_q   <= '0;
            datl_sh_q   <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_sh_q   <= addr_sh_d;
            dath_sh_q   <= dath_sh_d;
            datl_sh_q   <= datl_sh_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign frame_err = frame_err_q;

endmodule
